rst_seq_gen: RTL and testbench
==============================

// Module: rst_seq_gen
// PURPOSE
//  Parametrised reset generator/sequencer for the HDMI pipeline clock domain. Takes async
//  active-high reset plus async PLL lock; emits NUM_OUT synchronously released active-high
//  resets, deasserted one by one (index 0 first) after a minimum hold. Lock loss or a
//  software request re-asserts all outputs and restarts the sequence.
// PARAMETERS
//  SYNC_STAGES  2   flops in each synchroniser chain (>=2)
//  NUM_OUT      3   number of sequenced reset outputs (>=1)
//  HOLD_CYCLES  16  cycles with sync reset low and lock high before rst_out[0] releases (>=1)
//  STEP_CYCLES  8   cycles between consecutive rst_out releases (>=1)
//  CNT_W        localparam, $clog2(max(HOLD_CYCLES,STEP_CYCLES)+1)
// PORTS
//  clk         in   1        single clock domain
//  reset       in   1        asynchronous, active-high; async assert, sync release
//  pll_locked  in   1        asynchronous lock flag; synchronised internally
//  sw_rst_req  in   1        clk-synchronous single-cycle request to restart sequence
//  rst_out     out  NUM_OUT  active-high resets, registered, glitch-free
//  rst_done    out  1        high when every rst_out is deasserted
// BEHAVIOUR
//  - reset high (async, immediate): rst_out = all 1, rst_done = 0, both sync chains cleared
//    to reset-asserted/unlocked, FSM = HOLD, counter = 0.
//  - rst_sync: chain of SYNC_STAGES flops, async set by reset, shifts 0; goes low on edge
//    SYNC_STAGES after reset release. lock_sync: chain reset to 0, shifts pll_locked.
//  - Edges numbered from first rising clk edge after reset falls.
//  - FSM HOLD: counter increments each edge with rst_sync=0 && lock_sync=1; clears to 0 on any
//    edge where either fails. On the edge count==HOLD_CYCLES-1 and increment condition true:
//    -> RELEASE, rst_out[0] <= 0, idx <= 1, counter <= 0.
//  - FSM RELEASE: counter increments each edge; when counter==STEP_CYCLES-1: rst_out[idx]<=0,
//    idx++, counter<=0. After rst_out[NUM_OUT-1] clears: -> DONE next edge, rst_done <= 1.
//    NUM_OUT==1: RELEASE -> DONE on the edge after rst_out[0] clears.
//  - FSM DONE: hold outputs; rst_done=1.
//  - Abort (any state): sw_rst_req=1 or lock_sync=0 or rst_sync=1 on an edge -> rst_out<=all 1,
//    rst_done<=0, counter<=0, idx<=0, FSM<=HOLD. Abort wins over any release on the same edge.
//    sw_rst_req and lock loss together = single abort. A sw_rst_req in HOLD restarts the count.
//  - Lock-steady timing: rst_out[0] falls at edge E0=SYNC_STAGES+HOLD_CYCLES; rst_out[i] at
//    E0+i*STEP_CYCLES; rst_done rises at E0+(NUM_OUT-1)*STEP_CYCLES+1. Defaults: 18/26/34, done 35.
//  - rst_out released strictly in index order; never a higher index released before a lower.
//  - All outputs driven directly from flops; no combinational path from inputs to outputs.
// STRUCTURE
//  - rst_seq_pkg: FSM state encoding (HOLD, RELEASE, DONE), width helper function for CNT_W.
//  - Sub-module sync_bit_chain (params STAGES, RST_VAL): async-reset flop chain; instantiated
//    twice (reset release, pll_locked). Top holds FSM, counter, idx, output registers.
// TESTING
//  - Defaults, pll_locked=1, reset pulse 3 cycles -> rst_out 111 until edge 18, 110@18,
//    100@26, 000@34, rst_done=1@35.
//  - pll_locked drops for 1 cycle at edge 30 (lock_sync low ~edge 32) -> rst_out=111 next edge,
//    rst_done=0, full sequence repeats from count 0 after lock_sync high.
//  - sw_rst_req pulse while in DONE -> rst_out=111 next edge; rst_out[0] falls HOLD_CYCLES edges
//    after abort edge (lock steady, rst_sync already 0).
//  - reset asserted mid-RELEASE (rst_out=110) between edges -> rst_out=111, rst_done=0 with no
//    clock edge; release timing after deassert identical to first scenario.
//  - pll_locked=0 forever after reset -> rst_out stays 111, rst_done stays 0 for 200 cycles.
//  - NUM_OUT=1, HOLD_CYCLES=1, STEP_CYCLES=1, SYNC_STAGES=3 -> rst_out falls @4, rst_done @5.

Source files
------------

// File: rtl/rst_seq_pkg.sv
// Shared definitions for the reset sequencer: FSM state encoding and the
// helper that sizes the hold/step counter.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  // Counter must reach max(hold, step) - 1; one extra value keeps $clog2 >= 1.
  function automatic int cnt_width(input int hold_cycles, input int step_cycles);
    int max_v;
    max_v = (hold_cycles > step_cycles) ? hold_cycles : step_cycles;
    return $clog2(max_v + 1);
  endfunction

endpackage

// File: rtl/sync_bit_chain.sv
// Single-bit synchroniser: STAGES flops, async reset to RST_VAL, shifts i_d in.
// Output is the last flop; latency STAGES edges.
module sync_bit_chain #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_chain;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_chain <= {STAGES{RST_VAL}};
    end else begin
      r_chain <= {r_chain[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/rst_seq_gen.sv
// Reset sequencer: releases NUM_OUT registered resets in index order after a lock-qualified
// hold; lock loss, sw request or reset re-asserts all outputs and restarts the sequence.
module rst_seq_gen
  import rst_seq_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_OUT     = 3,
  parameter int HOLD_CYCLES = 16,
  parameter int STEP_CYCLES = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pll_locked,
  input  logic               sw_rst_req,
  output logic [NUM_OUT-1:0] rst_out,
  output logic               rst_done
);

  localparam int CNT_W = cnt_width(HOLD_CYCLES, STEP_CYCLES);
  localparam int IDX_W = $clog2(NUM_OUT + 1);

  logic w_rst_sync;
  logic w_lock_sync;
  logic w_abort;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [IDX_W-1:0]   r_idx;
  logic [NUM_OUT-1:0] r_rst_out;
  logic               r_done;

  state_t             w_state_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [IDX_W-1:0]   w_idx_nxt;
  logic [NUM_OUT-1:0] w_rst_out_nxt;
  logic               w_done_nxt;

  // Reset release chain is set by reset and drains zeros: async assert, sync release.
  sync_bit_chain #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b1)
  ) u_rst_sync (
    .i_clk (clk),
    .i_rst (reset),
    .i_d   (1'b0),
    .o_q   (w_rst_sync)
  );

  sync_bit_chain #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b0)
  ) u_lock_sync (
    .i_clk (clk),
    .i_rst (reset),
    .i_d   (pll_locked),
    .o_q   (w_lock_sync)
  );

  assign w_abort = sw_rst_req | ~w_lock_sync | w_rst_sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_HOLD;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_rst_out <= '1;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_idx     <= w_idx_nxt;
      r_rst_out <= w_rst_out_nxt;
      r_done    <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_idx_nxt     = r_idx;
    w_rst_out_nxt = r_rst_out;
    w_done_nxt    = r_done;

    // Abort takes priority over any release scheduled on the same edge.
    if (w_abort) begin
      w_state_nxt   = ST_HOLD;
      w_cnt_nxt     = '0;
      w_idx_nxt     = '0;
      w_rst_out_nxt = '1;
      w_done_nxt    = 1'b0;
    end else begin
      case (r_state)
        ST_HOLD: begin
          if (r_cnt == CNT_W'(HOLD_CYCLES - 1)) begin
            w_state_nxt      = ST_RELEASE;
            w_rst_out_nxt[0] = 1'b0;
            w_idx_nxt        = IDX_W'(1);
            w_cnt_nxt        = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end

        ST_RELEASE: begin
          if (r_idx == IDX_W'(NUM_OUT)) begin
            w_state_nxt = ST_DONE;
            w_done_nxt  = 1'b1;
            w_cnt_nxt   = '0;
          end else if (r_cnt == CNT_W'(STEP_CYCLES - 1)) begin
            for (int i = 0; i < NUM_OUT; i++) begin
              if (IDX_W'(i) == r_idx) begin
                w_rst_out_nxt[i] = 1'b0;
              end
            end
            w_idx_nxt = r_idx + IDX_W'(1);
            w_cnt_nxt = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end

        ST_DONE: begin
          w_done_nxt = 1'b1;
        end

        default: begin
          w_state_nxt   = ST_HOLD;
          w_cnt_nxt     = '0;
          w_idx_nxt     = '0;
          w_rst_out_nxt = '1;
          w_done_nxt    = 1'b0;
        end
      endcase
    end
  end

  assign rst_out  = r_rst_out;
  assign rst_done = r_done;

endmodule

// File: tb/tb_rst_seq_gen.sv
// Scoreboard bench: stimulus queues expected (edge, rst_out, rst_done) entries,
// monitors pop and compare whenever a DUT output changes or a checkpoint is requested.
module tb_rst_seq_gen;

  typedef struct {
    int         e;
    logic [2:0] r;
    logic       d;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       pll_locked = 1'b1;
  logic       sw_rst_req = 1'b0;
  logic [2:0] rst_out;
  logic       rst_done;

  logic       reset1 = 1'b0;
  logic [0:0] rst_out1;
  logic       rst_done1;

  int   edge_n = 0;
  int   edge1_n = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   mon_en = 1'b0;
  bit   mon1_en = 1'b0;
  event sample_ev;
  event sample1_ev;
  exp_t q0[$];
  exp_t q1[$];
  exp_t x0;
  exp_t x1;

  always #5 clk = ~clk;

  rst_seq_gen u_dut (
    .clk        (clk),
    .reset      (reset),
    .pll_locked (pll_locked),
    .sw_rst_req (sw_rst_req),
    .rst_out    (rst_out),
    .rst_done   (rst_done)
  );

  rst_seq_gen #(
    .SYNC_STAGES (3),
    .NUM_OUT     (1),
    .HOLD_CYCLES (1),
    .STEP_CYCLES (1)
  ) u_dut1 (
    .clk        (clk),
    .reset      (reset1),
    .pll_locked (1'b1),
    .sw_rst_req (1'b0),
    .rst_out    (rst_out1),
    .rst_done   (rst_done1)
  );

  // Edge numbering: first rising edge after reset falls is edge 1.
  always @(posedge clk) begin
    edge_n  <= reset  ? 0 : edge_n + 1;
    edge1_n <= reset1 ? 0 : edge1_n + 1;
  end

  initial forever begin
    @(rst_out or rst_done or sample_ev);
    #1;
    if (mon_en) begin
      n_cmp++;
      if (q0.size() == 0) begin
        n_bad++;
        $display("FAIL main_unexpected: edge %0d rst_out=%b rst_done=%b, required no change",
                 edge_n, rst_out, rst_done);
      end else begin
        x0 = q0.pop_front();
        if (x0.e !== edge_n || x0.r !== rst_out || x0.d !== rst_done) begin
          n_bad++;
          $display("FAIL main_step: got edge %0d rst_out=%b rst_done=%b, required edge %0d rst_out=%b rst_done=%b",
                   edge_n, rst_out, rst_done, x0.e, x0.r, x0.d);
        end
      end
    end
  end

  initial forever begin
    @(rst_out1 or rst_done1 or sample1_ev);
    #1;
    if (mon1_en) begin
      n_cmp++;
      if (q1.size() == 0) begin
        n_bad++;
        $display("FAIL small_unexpected: edge %0d rst_out=%b rst_done=%b, required no change",
                 edge1_n, rst_out1, rst_done1);
      end else begin
        x1 = q1.pop_front();
        if (x1.e !== edge1_n || x1.r[0] !== rst_out1[0] || x1.d !== rst_done1) begin
          n_bad++;
          $display("FAIL small_step: got edge %0d rst_out=%b rst_done=%b, required edge %0d rst_out=%b rst_done=%b",
                   edge1_n, rst_out1, rst_done1, x1.e, x1.r[0], x1.d);
        end
      end
    end
  end

  task automatic push0(input int e, input logic [2:0] r, input logic d);
    exp_t x;
    x.e = e; x.r = r; x.d = d;
    q0.push_back(x);
  endtask

  task automatic push1(input int e, input logic r, input logic d);
    exp_t x;
    x.e = e; x.r = {2'b00, r}; x.d = d;
    q1.push_back(x);
  endtask

  task automatic wait_edge(input int n);
    while (edge_n < n) @(negedge clk);
  endtask

  task automatic check_empty(input string nm, input int sz);
    n_cmp++;
    if (sz != 0) begin
      n_bad++;
      $display("FAIL %s_pending: %0d expected output changes never seen, required 0", nm, sz);
    end
  endtask

  // Called at a negedge; asserts reset asynchronously, holds 3 cycles, releases.
  task automatic pulse_reset();
    push0(edge_n, 3'b111, 1'b0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic push_nominal();
    push0(18, 3'b110, 1'b0);
    push0(26, 3'b100, 1'b0);
    push0(34, 3'b000, 1'b0);
    push0(35, 3'b000, 1'b1);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    #1 reset1 = 1'b1;
    #1 reset  = 1'b1;
    #1;
    mon_en  = 1'b1;
    mon1_en = 1'b1;
    push0(0, 3'b111, 1'b0);
    push1(0, 1'b1, 1'b0);
    -> sample_ev;
    -> sample1_ev;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Nominal release with lock steady.
    push_nominal();
    wait_edge(40);
    check_empty("nominal", q0.size());

    // Software request while done.
    sw_rst_req = 1'b1;
    push0(41, 3'b111, 1'b0);
    @(negedge clk);
    sw_rst_req = 1'b0;
    push0(57, 3'b110, 1'b0);
    push0(65, 3'b100, 1'b0);
    push0(73, 3'b000, 1'b0);
    push0(74, 3'b000, 1'b1);
    wait_edge(80);
    check_empty("sw_req", q0.size());

    // One-cycle lock drop sampled on edge 30.
    pulse_reset();
    push0(18, 3'b110, 1'b0);
    push0(26, 3'b100, 1'b0);
    push0(32, 3'b111, 1'b0);
    push0(48, 3'b110, 1'b0);
    push0(56, 3'b100, 1'b0);
    push0(64, 3'b000, 1'b0);
    push0(65, 3'b000, 1'b1);
    wait_edge(29);
    pll_locked = 1'b0;
    wait_edge(30);
    pll_locked = 1'b1;
    wait_edge(70);
    check_empty("lock_drop", q0.size());

    // Async reset in the middle of the release sequence.
    pulse_reset();
    push0(18, 3'b110, 1'b0);
    wait_edge(20);
    pulse_reset();
    push_nominal();
    wait_edge(40);
    check_empty("mid_reset", q0.size());

    // Lock never arrives.
    pll_locked = 1'b0;
    pulse_reset();
    repeat (200) @(negedge clk);
    check_empty("no_lock", q0.size());
    push0(edge_n, 3'b111, 1'b0);
    -> sample_ev;
    @(negedge clk);

    // Minimal configuration instance.
    reset1 = 1'b0;
    push1(4, 1'b0, 1'b0);
    push1(5, 1'b0, 1'b1);
    while (edge1_n < 10) @(negedge clk);
    check_empty("small", q1.size());
    check_empty("main_final", q0.size());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
